demux_stream: RTL and testbench

- 1-to-NOUT registered demultiplexer, the write/distribute counterpart of the mux2..mux64 selector family.
- Accepts one valid/ready input stream tagged with a destination index.
- Routes each beat into a one-entry holding register on the selected output channel; each channel has its own valid/ready handshake.
- Used to fan pipeline results out to per-unit consumers (e.g. writeback ports, per-FU queues).

---
 rtl/demux_stream.sv | 106 ++++++++++
 tb/tb_demux_stream.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// demux_stream: 1-to-NOUT registered stream demultiplexer.
//
// One valid/ready input stream carries a destination index with each beat.
// The beat is written into a one-entry holding register on that output
// channel. Each channel has its own valid/ready handshake. A channel can be
// drained and refilled in the same cycle, so a channel with a consumer that
// is always ready runs at one beat per cycle. A beat whose index has no
// channel behind it is consumed and dropped. The drop is flagged on err_sel
// and counted on err_cnt.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   the beat can be taken this cycle (combinational)
//   in_sel     destination channel index
//   in_data    input payload
//   out_valid  bit i: channel i holds a beat
//   out_ready  bit i: consumer i takes the beat this cycle
//   out_data   channel i payload in bits [i*WIDTH +: WIDTH]
//   err_sel    one-cycle pulse after an out-of-range beat was dropped
//   err_cnt    saturating count of dropped beats
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int NOUT  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NOUT-1:0]         out_valid,
    input  logic [NOUT-1:0]         out_ready,
    output logic [NOUT*WIDTH-1:0]   out_data,
    output logic                    err_sel,
    output logic [7:0]              err_cnt
);

    logic [NOUT-1:0]              valid_q, valid_d;
    logic [NOUT-1:0][WIDTH-1:0]   data_q,  data_d;
    logic                         err_sel_q, err_sel_d;
    logic [7:0]                   err_cnt_q, err_cnt_d;

    logic [NOUT-1:0] sel_hit;     // one-hot decode of in_sel
    logic [NOUT-1:0] ch_accept;   // channel is empty or is being drained now
    logic            in_range;
    logic            drop;

    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < NOUT; i++) begin
            sel_hit[i] = (in_sel == SEL_W'(i));
        end
        ch_accept = ~valid_q | out_ready;
        in_range  = |sel_hit;
        // An index with no channel behind it is always accepted, so the
        // beat is consumed and dropped instead of stalling the stream.
        in_ready  = in_range ? |(sel_hit & ch_accept) : 1'b1;
        drop      = in_valid & ~in_range;
    end

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        err_sel_d = drop;
        err_cnt_d = err_cnt_q;

        for (int i = 0; i < NOUT; i++) begin
            if (valid_q[i] && out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
            // A refill takes priority over the drain above. This is how a
            // channel drains and refills in one cycle without a bubble.
            if (in_valid && sel_hit[i] && ch_accept[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
            end
        end

        if (drop && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            data_q    <= '0;
            err_sel_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            err_sel_q <= err_sel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_sel   = err_sel_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream. The bench instantiates two copies of the
// design. The first copy has 4 channels and is used for routing, backpressure
// and reset. The second copy has 3 channels on a 2-bit index and is used for
// the out-of-range drop path.
module tb_demux_stream;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        err_sel;
    logic [7:0]  err_cnt;

    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  in_sel3;
    logic [7:0]  in_data3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic        err_sel3;
    logic [7:0]  err_cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    demux_stream #(.WIDTH(8), .SEL_W(2), .NOUT(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel),
        .err_cnt   (err_cnt)
    );

    demux_stream #(.WIDTH(8), .SEL_W(2), .NOUT(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_sel    (in_sel3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .err_sel   (err_sel3),
        .err_cnt   (err_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = 8'h00; out_ready3 = 3'b000;
        step(); step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0000", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_checks++;
        if (err_cnt !== 8'd0 || err_sel !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got cnt=%0d sel=%b want 0/0", err_cnt, err_sel);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_data got %h want 00000000", out_data);
        end
    endtask

    task automatic test_basic_route();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b1111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL route_in_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hA5) begin
            n_fail++; $display("FAIL route_out got valid=%b ch2=%h want 0100/a5", out_valid, out_data[23:16]);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0000 || out_data[23:16] !== 8'hA5) begin
            n_fail++; $display("FAIL route_drain got valid=%b ch2=%h want 0000/a5", out_valid, out_data[23:16]);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
        step();
        in_data = 8'h22;
        #1;
        n_checks++;
        if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h11) begin
            n_fail++; $display("FAIL bp_first got valid=%b ch1=%h want 0010/11", out_valid, out_data[15:8]);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall got in_ready=%b want 0", in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data[15:8] !== 8'h11) begin
            n_fail++; $display("FAIL bp_hold got rdy=%b valid=%b ch1=%h want 0/0010/11", in_ready, out_valid, out_data[15:8]);
        end
        out_ready = 4'b1111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h22) begin
            n_fail++; $display("FAIL bp_refill got valid=%b ch1=%h want 0010/22", out_valid, out_data[15:8]);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL bp_drain got valid=%b want 0000", out_valid);
        end
    endtask

    task automatic test_independent();
        out_ready = 4'b0110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h44;
        step();
        in_sel = 2'd3; in_data = 8'h33;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL indep_in_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b1001 || out_data[7:0] !== 8'h44 || out_data[31:24] !== 8'h33) begin
            n_fail++; $display("FAIL indep_out got valid=%b ch0=%h ch3=%h want 1001/44/33",
                               out_valid, out_data[7:0], out_data[31:24]);
        end
        out_ready = 4'b1111;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL indep_drain got valid=%b want 0000", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        logic saw_valid;
        saw_valid = 1'b0;
        out_ready3 = 3'b111;
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hEE;
        #1;
        n_checks++;
        if (in_ready3 !== 1'b1) begin
            n_fail++; $display("FAIL oor_in_ready got %b want 1", in_ready3);
        end
        for (int k = 1; k <= 300; k++) begin
            step();
            if (out_valid3 !== 3'b000) saw_valid = 1'b1;
            if (k == 1) begin
                n_checks++;
                if (err_sel3 !== 1'b1 || err_cnt3 !== 8'd1) begin
                    n_fail++; $display("FAIL oor_first got sel=%b cnt=%0d want 1/1", err_sel3, err_cnt3);
                end
            end
            if (k == 254) begin
                n_checks++;
                if (err_cnt3 !== 8'd254) begin
                    n_fail++; $display("FAIL oor_cnt254 got %0d want 254", err_cnt3);
                end
            end
        end
        n_checks++;
        if (err_cnt3 !== 8'd255 || err_sel3 !== 1'b1) begin
            n_fail++; $display("FAIL oor_saturate got cnt=%0d sel=%b want 255/1", err_cnt3, err_sel3);
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++; $display("FAIL oor_no_valid got out_valid activity=%b want 0", saw_valid);
        end
        in_sel3 = 2'd2; in_data3 = 8'h9C;
        step();
        in_valid3 = 1'b0;
        n_checks++;
        if (out_valid3 !== 3'b100 || out_data3[23:16] !== 8'h9C || err_sel3 !== 1'b0 || err_cnt3 !== 8'd255) begin
            n_fail++; $display("FAIL oor_inrange got valid=%b ch2=%h sel=%b cnt=%0d want 100/9c/0/255",
                               out_valid3, out_data3[23:16], err_sel3, err_cnt3);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h55;
        step();
        in_sel = 2'd3; in_data = 8'h66;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b1010) begin
            n_fail++; $display("FAIL areset_setup got valid=%b want 1010", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
            n_fail++; $display("FAIL areset_immediate got valid=%b data=%h want 0000/0", out_valid, out_data);
        end
        n_checks++;
        if (err_cnt3 !== 8'd0 || out_valid3 !== 3'b000) begin
            n_fail++; $display("FAIL areset_dut3 got cnt=%0d valid=%b want 0/000", err_cnt3, out_valid3);
        end
        step();
        #2 rst_n = 1'b1;
        step();
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h77) begin
            n_fail++; $display("FAIL areset_after got valid=%b ch0=%h want 0001/77", out_valid, out_data[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_backpressure();
        test_independent();
        test_out_of_range();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
